// File: rtl/regbank_pkg.sv
// Shared defaults, write-back delay range check and reset constant for the
// pipelined register bank.
package regbank_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int WB_DELAY_MIN = 0;
    localparam int WB_DELAY_MAX = 3;

    localparam logic [63:0] ZERO_WORD = '0;

    function automatic bit wbDelayLegal(input int delay);
        return (delay >= WB_DELAY_MIN) && (delay <= WB_DELAY_MAX);
    endfunction

endpackage

// File: rtl/regbank_wb_delay.sv
// {valid, addr} shift pipeline that delays a write-back request by WB_DELAY
// edges; WB_DELAY=0 is a straight pass-through.
module regbank_wb_delay
    import regbank_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WB_DELAY = 1
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_WriteBack,
    input  logic [ADDR_W-1:0] i_AddrRegDest,
    output logic              o_CommitValid,
    output logic [ADDR_W-1:0] o_CommitAddr,
    output logic              o_WritePending
);

    if (!wbDelayLegal(WB_DELAY)) begin : gBadDelay
        $error("regbank_wb_delay: WB_DELAY=%0d outside legal range", WB_DELAY);
    end

    if (WB_DELAY == 0) begin : gPassThrough
        logic unusedInputs;
        assign unusedInputs   = i_CLK ^ i_RST_N;
        assign o_CommitValid  = i_WriteBack;
        assign o_CommitAddr   = i_AddrRegDest;
        assign o_WritePending = 1'b0;
    end else begin : gPipe
        logic [WB_DELAY-1:0] validStage;
        logic [ADDR_W-1:0]   addrStage [WB_DELAY];
        logic                pendingReg;

        // Pending is a registered OR of the stages: it rises the edge after
        // capture and falls the edge after the final commit.
        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                validStage <= '0;
                pendingReg <= 1'b0;
                for (int i = 0; i < WB_DELAY; i++) begin
                    addrStage[i] <= '0;
                end
            end else begin
                validStage[0] <= i_WriteBack;
                addrStage[0]  <= i_AddrRegDest;
                for (int i = 1; i < WB_DELAY; i++) begin
                    validStage[i] <= validStage[i-1];
                    addrStage[i]  <= addrStage[i-1];
                end
                pendingReg <= |validStage;
            end
        end

        assign o_CommitValid  = validStage[WB_DELAY-1];
        assign o_CommitAddr   = addrStage[WB_DELAY-1];
        assign o_WritePending = pendingReg;
    end

endmodule

// File: rtl/regbank_pipelined.sv
// 2-read / 1-write register bank with registered reads, delayed write-back
// commit, optional write-to-read bypass and optional hard-wired zero register.
module regbank_pipelined
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WB_DELAY = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic [ADDR_W-1:0] i_AddrReg1,
    input  logic [ADDR_W-1:0] i_AddrReg2,
    input  logic              i_ReadEn,
    input  logic [ADDR_W-1:0] i_AddrRegDest,
    input  logic              i_WriteBack,
    input  logic [DATA_W-1:0] i_WriteData,
    output logic [DATA_W-1:0] o_Data1,
    output logic [DATA_W-1:0] o_Data2,
    output logic [DATA_W-1:0] o_RegShowing1,
    output logic [DATA_W-1:0] o_RegShowing2,
    output logic              o_WritePending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]         regArray [DEPTH];
    logic                      commitValid;
    logic [ADDR_W-1:0]         commitAddr;
    logic                      commitEn;
    logic [1:0][ADDR_W-1:0]    readAddr;

    regbank_wb_delay #(
        .ADDR_W   (ADDR_W),
        .WB_DELAY (WB_DELAY)
    ) uWbDelay (
        .i_CLK          (i_CLK),
        .i_RST_N        (i_RST_N),
        .i_WriteBack    (i_WriteBack),
        .i_AddrRegDest  (i_AddrRegDest),
        .o_CommitValid  (commitValid),
        .o_CommitAddr   (commitAddr),
        .o_WritePending (o_WritePending)
    );

    assign commitEn = commitValid && !(ZERO_REG && (commitAddr == '0));

    // Storage is flop-based: it needs a true reset and asynchronous debug reads.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regArray[i] <= DATA_W'(ZERO_WORD);
            end
        end else if (commitEn) begin
            regArray[commitAddr] <= i_WriteData;
        end
    end

    assign readAddr = {i_AddrReg2, i_AddrReg1};

    for (genvar gi = 0; gi < 2; gi++) begin : gReadPort
        logic              isZero;
        logic              bypassHit;
        logic [DATA_W-1:0] showData;
        logic [DATA_W-1:0] nextData;
        logic [DATA_W-1:0] dataReg;

        assign isZero    = ZERO_REG && (readAddr[gi] == '0);
        assign showData  = isZero ? DATA_W'(ZERO_WORD) : regArray[readAddr[gi]];
        assign bypassHit = BYPASS && commitEn && (commitAddr == readAddr[gi]);
        assign nextData  = bypassHit ? i_WriteData : showData;

        always_ff @(posedge i_CLK or negedge i_RST_N) begin
            if (!i_RST_N) begin
                dataReg <= DATA_W'(ZERO_WORD);
            end else if (i_ReadEn) begin
                dataReg <= nextData;
            end
        end
    end

    assign o_Data1       = gReadPort[0].dataReg;
    assign o_Data2       = gReadPort[1].dataReg;
    assign o_RegShowing1 = gReadPort[0].showData;
    assign o_RegShowing2 = gReadPort[1].showData;

endmodule

// File: tb/tb_regbank_pipelined.sv
// Scoreboard bench: three bank configurations driven one at a time; read
// results are queued at issue and compared by a monitor when they appear.
module tb_regbank_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic [2:0] re, wb, pend, rv;
    logic [2:0] addr1 [3];
    logic [2:0] addr2 [3];
    logic [2:0] dest  [3];
    logic [7:0] wdata [3];
    logic [7:0] data1 [3];
    logic [7:0] data2 [3];
    logic [7:0] show1 [3];
    logic [7:0] show2 [3];

    int passed = 0;
    int total  = 0;

    typedef struct {
        int         dut;
        logic [7:0] e1;
        logic [7:0] e2;
        string      tag;
    } exp_t;
    exp_t sbQ[$];

    // A: delay 1, bypass, zero reg.  B: delay 2, no bypass.  C: delay 0, bypass.
    regbank_pipelined #(.DATA_W(8), .ADDR_W(3), .WB_DELAY(1), .BYPASS(1'b1), .ZERO_REG(1'b1)) uA (
        .i_CLK(clk), .i_RST_N(rstN), .i_AddrReg1(addr1[0]), .i_AddrReg2(addr2[0]),
        .i_ReadEn(re[0]), .i_AddrRegDest(dest[0]), .i_WriteBack(wb[0]), .i_WriteData(wdata[0]),
        .o_Data1(data1[0]), .o_Data2(data2[0]), .o_RegShowing1(show1[0]), .o_RegShowing2(show2[0]),
        .o_WritePending(pend[0]));

    regbank_pipelined #(.DATA_W(8), .ADDR_W(3), .WB_DELAY(2), .BYPASS(1'b0), .ZERO_REG(1'b0)) uB (
        .i_CLK(clk), .i_RST_N(rstN), .i_AddrReg1(addr1[1]), .i_AddrReg2(addr2[1]),
        .i_ReadEn(re[1]), .i_AddrRegDest(dest[1]), .i_WriteBack(wb[1]), .i_WriteData(wdata[1]),
        .o_Data1(data1[1]), .o_Data2(data2[1]), .o_RegShowing1(show1[1]), .o_RegShowing2(show2[1]),
        .o_WritePending(pend[1]));

    regbank_pipelined #(.DATA_W(8), .ADDR_W(3), .WB_DELAY(0), .BYPASS(1'b1), .ZERO_REG(1'b0)) uC (
        .i_CLK(clk), .i_RST_N(rstN), .i_AddrReg1(addr1[2]), .i_AddrReg2(addr2[2]),
        .i_ReadEn(re[2]), .i_AddrRegDest(dest[2]), .i_WriteBack(wb[2]), .i_WriteData(wdata[2]),
        .o_Data1(data1[2]), .o_Data2(data2[2]), .o_RegShowing1(show1[2]), .o_RegShowing2(show2[2]),
        .o_WritePending(pend[2]));

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
        else passed++;
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) $display("FAIL %s: got %b, required %b", name, act, req);
        else passed++;
    endtask

    // A read issued on edge T is presented on o_DataN after T.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) rv <= '0;
        else       rv <= re;
    end

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rv[d]) begin
                if (sbQ.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_read dut%0d: got %h/%h, required no read", d, data1[d], data2[d]);
                end else begin
                    e = sbQ.pop_front();
                    $display("read %s dut%0d data1=%h data2=%h", e.tag, d, data1[d], data2[d]);
                    check8({e.tag, "_dut"}, 8'(d), 8'(e.dut));
                    check8({e.tag, "_d1"}, data1[d], e.e1);
                    check8({e.tag, "_d2"}, data2[d], e.e2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        re = '0;
        wb = '0;
        for (int d = 0; d < 3; d++) begin
            addr1[d] = '0; addr2[d] = '0; dest[d] = '0; wdata[d] = '0;
        end
    endtask

    task automatic drive(input int d, input logic w, input logic [2:0] dst, input logic [7:0] wd,
                         input logic r, input logic [2:0] a1, input logic [2:0] a2);
        wb[d] = w; dest[d] = dst; wdata[d] = wd; re[d] = r; addr1[d] = a1; addr2[d] = a2;
    endtask

    task automatic expectRead(input int d, input string tag, input logic [7:0] e1, input logic [7:0] e2);
        exp_t e;
        e.dut = d; e.e1 = e1; e.e2 = e2; e.tag = tag;
        sbQ.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0;
        idleAll();
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            check8($sformatf("reset_data1_dut%0d", d), data1[d], 8'h00);
            check8($sformatf("reset_data2_dut%0d", d), data2[d], 8'h00);
            check1($sformatf("reset_pend_dut%0d", d), pend[d], 1'b0);
        end
        rstN = 1'b1;
        tick();

        // A: basic write then read of R5
        drive(0, 1, 5, 8'h00, 0, 5, 5); tick();
        check1("A_pend_capture", pend[0], 1'b0);
        drive(0, 0, 0, 8'h3C, 0, 5, 5); tick();
        check8("A_show_R5", show1[0], 8'h3C);
        check1("A_pend_high", pend[0], 1'b1);
        drive(0, 0, 0, 8'h00, 1, 5, 5); expectRead(0, "A_readR5", 8'h3C, 8'h3C); tick();
        check1("A_pend_fall", pend[0], 1'b0);

        // A: bypass of a commit to R2 onto both read ports
        drive(0, 1, 2, 8'h00, 0, 2, 2); tick();
        drive(0, 0, 0, 8'h77, 1, 2, 2); expectRead(0, "A_bypassR2", 8'h77, 8'h77); tick();
        check8("A_show_R2", show1[0], 8'h77);

        // A: zero register ignores writes, including the bypass path
        drive(0, 1, 0, 8'h00, 0, 0, 0); tick();
        drive(0, 0, 0, 8'hFF, 1, 0, 0); expectRead(0, "A_zeroBypass", 8'h00, 8'h00); tick();
        check8("A_show_R0", show1[0], 8'h00);
        drive(0, 0, 0, 8'h00, 1, 0, 0); expectRead(0, "A_readR0", 8'h00, 8'h00); tick();

        // A: back-to-back writes to R7
        drive(0, 1, 7, 8'h00, 0, 7, 7); tick();
        drive(0, 1, 7, 8'h11, 0, 7, 7); tick();
        check8("A_b2b_first", show1[0], 8'h11);
        check1("A_b2b_pend1", pend[0], 1'b1);
        drive(0, 0, 0, 8'h22, 0, 7, 7); tick();
        check8("A_b2b_second", show1[0], 8'h22);
        check1("A_b2b_pend2", pend[0], 1'b1);
        drive(0, 0, 0, 8'h00, 1, 7, 5); expectRead(0, "A_readR7R5", 8'h22, 8'h3C); tick();
        check1("A_b2b_pendfall", pend[0], 1'b0);

        // A: hold with i_ReadEn low while addresses move
        drive(0, 0, 0, 8'h00, 0, 3, 2); tick(); tick();
        check8("A_hold_d1", data1[0], 8'h22);
        check8("A_hold_d2", data2[0], 8'h3C);
        check8("A_show_R3", show1[0], 8'h00);
        check8("A_show2_R2", show2[0], 8'h77);

        // B: two-cycle delay, no bypass -> same-edge read sees old value
        drive(1, 1, 2, 8'h00, 0, 2, 2); tick();
        check1("B_pend_capture", pend[1], 1'b0);
        drive(1, 0, 0, 8'h00, 0, 2, 2); tick();
        check1("B_pend_rise", pend[1], 1'b1);
        drive(1, 0, 0, 8'h77, 1, 2, 2); expectRead(1, "B_noBypassR2", 8'h00, 8'h00); tick();
        check8("B_show_R2", show1[1], 8'h77);
        check1("B_pend_commit", pend[1], 1'b1);
        drive(1, 0, 0, 8'h00, 1, 2, 2); expectRead(1, "B_readR2", 8'h77, 8'h77); tick();
        check1("B_pend_fall", pend[1], 1'b0);
        drive(1, 0, 0, 8'h00, 0, 2, 2); tick();

        // B: reset while a write to R3 is in flight
        drive(1, 1, 3, 8'hA5, 0, 3, 2); tick();
        drive(1, 0, 0, 8'hA5, 0, 3, 2);
        rstN = 1'b0;
        #1;
        check1("B_rst_pend", pend[1], 1'b0);
        check8("B_rst_d1", data1[1], 8'h00);
        check8("B_rst_d2", data2[1], 8'h00);
        tick(); tick();
        rstN = 1'b1;
        tick(); tick();
        check8("B_rst_R3", show1[1], 8'h00);
        check8("B_rst_R2", show2[1], 8'h00);
        check1("B_rst_pend_after", pend[1], 1'b0);
        check8("A_rst_R2", show2[0], 8'h00);
        drive(1, 0, 0, 8'h00, 0, 0, 0);

        // C: zero delay, write and read on the same edge
        drive(2, 1, 4, 8'h5A, 1, 4, 1); expectRead(2, "C_sameEdgeR4", 8'h5A, 8'h00); tick();
        check8("C_show_R4", show1[2], 8'h5A);
        check1("C_pend_zero", pend[2], 1'b0);
        drive(2, 0, 0, 8'h00, 1, 1, 4); expectRead(2, "C_readR1R4", 8'h00, 8'h5A); tick();
        drive(2, 1, 4, 8'h66, 0, 4, 4); tick();
        drive(2, 0, 0, 8'h00, 1, 4, 4); expectRead(2, "C_overwriteR4", 8'h66, 8'h66); tick();

        idleAll();
        tick(); tick(); tick();
        check8("sb_drained", 8'(sbQ.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
